// File: rtl/ssm_se_packer.sv
// Substream SE packer: packs variable-length syntax elements MSB-first
// into fixed-size mux words, zero-pads the last word at slice end.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ssm_max_se_size     mux word size in bits (change only when idle)
//   se_data/se_size     right-aligned SE bits and their count
//   se_valid/se_ready   SE handshake
//   slice_end           last SE of slice marker
//   mux_word(_valid/_ready) packed word handshake
//   flush_done          one-cycle pulse once a slice is fully emitted
//   word_count          words emitted since reset (wraps)
//   fullness            pending bits in the accumulator
module ssm_se_packer #(
  parameter int MAX_SE_SIZE = 248,
  parameter int ACC_W       = 2*MAX_SE_SIZE-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             ssm_max_se_size,
  input  logic [MAX_SE_SIZE-1:0] se_data,
  input  logic [8:0]             se_size,
  input  logic                   se_valid,
  output logic                   se_ready,
  input  logic                   slice_end,
  output logic [255:0]           mux_word,
  output logic                   mux_word_valid,
  input  logic                   mux_word_ready,
  output logic                   flush_done,
  output logic [15:0]            word_count,
  output logic [8:0]             fullness
);

  localparam int EXT_W = (ACC_W > 256) ? ACC_W : 256;

  typedef enum logic [1:0] {
    RUN,
    PAD,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [255:0]       word_q, word_d;
  logic               valid_q, valid_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [8:0]         full_q, full_d;

  logic [9:0]         size_w, full_w, se_w, full_nx;
  logic               out_free, accept;
  logic               word_fire, pad_fire;
  logic [ACC_W-1:0]   se_mask, sz_mask, f_mask;
  logic [ACC_W-1:0]   se_bits, emit_full, emit_pad;
  logic [EXT_W-1:0]   full_ext, pad_ext;

  assign size_w = {2'b00, ssm_max_se_size};
  assign full_w = {1'b0, full_q};
  assign se_w   = {1'b0, se_size};

  assign out_free = ~valid_q | mux_word_ready;
  assign se_ready = (state_q == RUN) & (full_w < size_w);
  assign accept   = se_valid & se_ready;

  assign word_fire = (full_w >= size_w) & out_free;
  // Leftover tail of a slice, only once no full word remains.
  assign pad_fire  = (state_q == PAD) & (full_q != 9'd0)
                   & (full_w < size_w) & out_free;

  assign se_mask = ~({ACC_W{1'b1}} << se_w);
  assign sz_mask = ~({ACC_W{1'b1}} << size_w);
  assign f_mask  = ~({ACC_W{1'b1}} << full_w);

  assign se_bits = ACC_W'(se_data) & se_mask;

  // Oldest pending bit sits at acc[fullness-1]; bits above it are stale.
  assign emit_full = (acc_q >> (full_w - size_w)) & sz_mask;
  assign emit_pad  = (acc_q & f_mask) << (size_w - full_w);

  assign full_ext = EXT_W'(emit_full);
  assign pad_ext  = EXT_W'(emit_pad);

  always_comb begin
    acc_d   = acc_q;
    full_nx = full_w;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      acc_d   = (acc_q << se_w) | se_bits;
      full_nx = full_nx + se_w;
    end
    if (word_fire) begin
      word_d  = full_ext[255:0];
      valid_d = 1'b1;
      full_nx = full_nx - size_w;
      cnt_d   = cnt_q + 16'd1;
    end else if (pad_fire) begin
      word_d  = pad_ext[255:0];
      valid_d = 1'b1;
      full_nx = 10'd0;
      cnt_d   = cnt_q + 16'd1;
    end else if (mux_word_ready) begin
      valid_d = 1'b0;
    end
    full_d = full_nx[8:0];
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      RUN: begin
        if (slice_end) state_d = PAD;
      end
      PAD: begin
        if ((full_q == 9'd0) && out_free)
          state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      full_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign mux_word       = word_q;
  assign mux_word_valid = valid_q;
  assign word_count     = cnt_q;
  assign fullness       = full_q;

  a_se_size_legal: assert property (
    @(posedge clk) disable iff (rst)
    se_valid |-> (se_w <= size_w)
  );

endmodule

// File: tb/tb_ssm_se_packer.sv
// Bench for ssm_se_packer: bit-queue reference model feeding an
// expected-word scoreboard, checked by an independent monitor.
module tb_ssm_se_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ssz;
  logic [247:0] se_data;
  logic [8:0]   se_size;
  logic         se_valid, se_ready, slice_end;
  logic [255:0] mux_word;
  logic         mux_word_valid, mux_word_ready;
  logic         flush_done;
  logic [15:0]  word_count;
  logic [8:0]   fullness;

  ssm_se_packer dut (
    .clk            (clk),
    .rst            (rst),
    .ssm_max_se_size(ssz),
    .se_data        (se_data),
    .se_size        (se_size),
    .se_valid       (se_valid),
    .se_ready       (se_ready),
    .slice_end      (slice_end),
    .mux_word       (mux_word),
    .mux_word_valid (mux_word_valid),
    .mux_word_ready (mux_word_ready),
    .flush_done     (flush_done),
    .word_count     (word_count),
    .fullness       (fullness)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit           bq[$];
  logic [255:0] expq[$];
  int           model_words = 0;
  int           exp_flush   = 0;
  int           flush_seen  = 0;
  logic [255:0] last_word   = '0;
  int           ready_mode  = 0;

  task automatic chk(string name, logic [255:0] act,
                     logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [247:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[247:0];
  endfunction

  function automatic void model_word(int n);
    logic [255:0] w = '0;
    int s = int'(ssz);
    for (int j = 0; j < n; j++) w[s-1-j] = bq.pop_front();
    expq.push_back(w);
    model_words++;
  endfunction

  function automatic void model_push(int sz, logic [247:0] d,
                                     bit e);
    for (int i = sz - 1; i >= 0; i--) bq.push_back(d[i]);
    while (bq.size() >= int'(ssz)) model_word(int'(ssz));
    if (e) begin
      if (bq.size() > 0) model_word(bq.size());
      exp_flush++;
    end
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      0:       mux_word_ready = 1'b1;
      1:       mux_word_ready = 1'b0;
      default: mux_word_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    #3;
    if (rst === 1'b0) begin
      if (flush_done === 1'b1) flush_seen++;
      if (mux_word_valid && mux_word_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h want none", mux_word);
        end else begin
          chk("word", mux_word, expq.pop_front());
          last_word = mux_word;
        end
      end
    end
  end

  task automatic send(int sz, logic [247:0] d, bit e);
    int n = 0;
    while (!se_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!se_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got se_ready=0 want 1");
      return;
    end
    se_valid  = 1'b1;
    se_size   = 9'(sz);
    se_data   = d;
    slice_end = e;
    model_push(sz, d, e);
    @(negedge clk);
    se_valid  = 1'b0;
    slice_end = 1'b0;
  endtask

  task automatic slice_only();
    slice_end = 1'b1;
    model_push(0, '0, 1'b1);
    @(negedge clk);
    slice_end = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (n < 3000 && !(expq.size() == 0 && !mux_word_valid
           && flush_seen == exp_flush && se_ready)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy want idle", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [247:0] a, b, d;
    logic [255:0] e;
    int f0, n;

    rst = 1'b1;
    ssz = 8'd128;
    se_data = '0;
    se_size = '0;
    se_valid = 1'b0;
    slice_end = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", mux_word_valid, 0);
    chk("rst_full", fullness, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_flush", flush_done, 0);
    chk("rst_word", mux_word, 0);
    chk("rst_ready", se_ready, 1);

    // 1: 100 + 28 bits make exactly one 128-bit word
    a = rnd();
    b = rnd();
    send(100, a, 1'b0);
    send(28, b, 1'b0);
    a = a & ~({248{1'b1}} << 100);
    b = b & ~({248{1'b1}} << 28);
    e = (256'(a) << 28) | 256'(b);
    chk("t1_full128", fullness, 128);
    chk("t1_valid_pre", mux_word_valid, 0);
    @(negedge clk);
    chk("t1_valid", mux_word_valid, 1);
    chk("t1_word", mux_word, e);
    chk("t1_full0", fullness, 0);
    wait_idle("t1");

    // 2: backpressure while second word builds up
    ready_mode = 1;
    @(negedge clk);
    send(100, rnd(), 1'b0);
    send(100, rnd(), 1'b0);
    chk("t2_full200", fullness, 200);
    chk("t2_ready_lo", se_ready, 0);
    @(negedge clk);
    chk("t2_full72", fullness, 72);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_v", mux_word_valid, 1);
      chk("t2_hold_w", mux_word, expq[0]);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_idle("t2");
    chk("t2_end72", fullness, 72);
    chk("t2_model", fullness, bq.size());
    slice_only();
    wait_idle("t2f");
    chk("t2_flushed", fullness, 0);

    // 3: size 64, three 40-bit SEs back to back
    ssz = 8'd64;
    send(40, rnd(), 1'b0);
    chk("t3_f40", fullness, 40);
    send(40, rnd(), 1'b0);
    send(40, rnd(), 1'b0);
    chk("t3_f56", fullness, 56);
    wait_idle("t3");
    chk("t3_end56", fullness, 56);
    chk("t3_wc", word_count, model_words);
    slice_only();
    wait_idle("t3f");

    // 4: SE together with slice_end gets padded
    f0 = flush_seen;
    d = '0;
    d[19:0] = 20'hABCDE;
    send(20, d, 1'b1);
    wait_idle("t4");
    chk("t4_word", last_word, 256'h0000ABCDE << 44);
    chk("t4_flush", flush_seen - f0, 1);
    chk("t4_ready", se_ready, 1);

    // 5: slice_end with nothing pending
    n = model_words;
    slice_end = 1'b1;
    model_push(0, '0, 1'b1);
    @(negedge clk);
    slice_end = 1'b0;
    chk("t5_flush_lo", flush_done, 0);
    @(negedge clk);
    chk("t5_flush_hi", flush_done, 1);
    @(negedge clk);
    chk("t5_flush_end", flush_done, 0);
    wait_idle("t5");
    chk("t5_nowords", model_words, n);
    chk("t5_wc", word_count, n);

    // 6: reset with pending bits and a held word
    ready_mode = 1;
    @(negedge clk);
    send(60, rnd(), 1'b0);
    send(40, rnd(), 1'b0);
    send(54, rnd(), 1'b0);
    chk("t6_f90", fullness, 90);
    chk("t6_held", mux_word_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bq.delete();
    expq.delete();
    model_words = 0;
    exp_flush = flush_seen;
    chk("t6_valid", mux_word_valid, 0);
    chk("t6_full", fullness, 0);
    chk("t6_wc", word_count, 0);
    ready_mode = 0;
    d = rnd();
    send(64, d, 1'b0);
    wait_idle("t6");
    chk("t6_word", last_word, 256'(d[63:0]));
    chk("t6_wc1", word_count, 1);

    // random slices with random sizes and backpressure
    for (int r = 0; r < 8; r++) begin
      ssz = 8'($urandom_range(1, 248));
      ready_mode = 2;
      n = $urandom_range(3, 25);
      for (int k = 0; k < n; k++)
        send($urandom_range(0, int'(ssz)), rnd(), k == n - 1);
      wait_idle("rnd");
      chk("rnd_full", fullness, 0);
      chk("rnd_wc", word_count, 16'(model_words));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
